// File: rtl/spike_decoder.sv
// Spike-count classifier for the output layer of a spiking network.
// Counts spikes per neuron over a fixed window, then scans the counters
// one neuron per cycle to pick the most active neuron (lowest index wins
// ties) and holds the result until the consumer accepts it.
module spike_decoder #(
    parameter int NUM_NEURONS = 4,
    parameter int WINDOW      = 100,
    parameter int CNT_WIDTH   = 16,
    localparam int IDX_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NUM_NEURONS-1:0] spike_in,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IDX_W-1:0]       out_class,
    output logic [CNT_WIDTH-1:0]   out_count,
    output logic                   out_tie
);

    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COUNT = 2'd1;
    localparam logic [1:0] SCAN  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_NEURONS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    logic [1:0]           r_state;
    logic [WIN_W-1:0]     r_win;
    logic [IDX_W-1:0]     r_idx;
    logic [CNT_WIDTH-1:0] r_cnt [NUM_NEURONS];
    logic [IDX_W-1:0]     r_class;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_tie;
    logic                 r_valid;

    logic [CNT_WIDTH-1:0] w_scanCnt;

    // Select the counter currently being examined by the scan.
    always_comb begin
        w_scanCnt = r_cnt[r_idx];
    end

    // Per-neuron saturating spike counters: cleared on an accepted start,
    // incremented only during the observation window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (r_state == IDLE && start) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (r_state == COUNT) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (spike_in[i] && r_cnt[i] != CNT_MAX) begin
                    r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Main sequencer: window timing, winner scan and result handshake.
    // The result registers double as the scan's running best, so they are
    // cleared on start and otherwise keep their value after the handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_win   <= '0;
            r_idx   <= '0;
            r_class <= '0;
            r_count <= '0;
            r_tie   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_win   <= '0;
                        r_idx   <= '0;
                        r_class <= '0;
                        r_count <= '0;
                        r_tie   <= 1'b0;
                        r_state <= COUNT;
                    end
                end
                COUNT: begin
                    if (r_win == WIN_LAST) begin
                        r_idx   <= '0;
                        r_state <= SCAN;
                    end else begin
                        r_win <= r_win + WIN_W'(1);
                    end
                end
                SCAN: begin
                    if (r_idx == '0) begin
                        r_class <= '0;
                        r_count <= w_scanCnt;
                        r_tie   <= 1'b0;
                    end else if (w_scanCnt > r_count) begin
                        r_class <= r_idx;
                        r_count <= w_scanCnt;
                        r_tie   <= 1'b0;
                    end else if (w_scanCnt == r_count) begin
                        r_tie <= 1'b1;
                    end
                    if (r_idx == IDX_LAST) begin
                        r_valid <= 1'b1;
                        r_state <= HOLD;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign out_valid = r_valid;
    assign out_class = r_class;
    assign out_count = r_count;
    assign out_tie   = r_tie;

endmodule

// File: tb/tb_spike_decoder.sv
// Directed testbench for spike_decoder: window counting, winner scan,
// tie handling, saturation, hold/handshake behaviour and async reset.
module tb_spike_decoder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  spikeIn;
    logic        busy;
    logic        outValid;
    logic        outReady;
    logic [1:0]  outClass;
    logic [15:0] outCount;
    logic        outTie;

    logic        startS;
    logic [3:0]  spikeInS;
    logic        busyS;
    logic        outValidS;
    logic        outReadyS;
    logic [1:0]  outClassS;
    logic [2:0]  outCountS;
    logic        outTieS;

    int checkCount;
    int failCount;
    int lastLatency;
    int holdErr;
    logic [3:0] stimVec [10];

    spike_decoder #(.NUM_NEURONS(4), .WINDOW(10), .CNT_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .spike_in  (spikeIn),
        .busy      (busy),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_class (outClass),
        .out_count (outCount),
        .out_tie   (outTie)
    );

    spike_decoder #(.NUM_NEURONS(4), .WINDOW(10), .CNT_WIDTH(3)) dutSat (
        .clk       (clk),
        .rst       (rst),
        .start     (startS),
        .spike_in  (spikeInS),
        .busy      (busyS),
        .out_valid (outValidS),
        .out_ready (outReadyS),
        .out_class (outClassS),
        .out_count (outCountS),
        .out_tie   (outTieS)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single point of comparison: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Pulse start (with startSpike present in the start cycle), drive stimVec
    // over the ten COUNT cycles, then wait (bounded) for out_valid and record
    // how many cycles after the start edge it appeared.
    task automatic applyStimulus(input logic [3:0] startSpike);
        int cyc;
        @(negedge clk);
        start   = 1'b1;
        spikeIn = startSpike;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        for (int i = 0; i < 10; i++) begin
            spikeIn = stimVec[i];
            @(negedge clk);
            cyc++;
        end
        spikeIn = 4'b0000;
        while (!outValid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        lastLatency = cyc;
        checkOutput("validSeen", 32'(outValid), 32'd1);
    endtask

    // Accept the held result and confirm the decoder drops back to idle.
    task automatic finishHold(input string tag);
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        checkOutput({tag, "_validLow"}, 32'(outValid), 32'd0);
        checkOutput({tag, "_busyLow"}, 32'(busy), 32'd0);
    endtask

    // Directed test sequence.
    initial begin
        checkCount = 0;
        failCount  = 0;
        rst        = 1'b0;
        start      = 1'b0;
        spikeIn    = 4'b0000;
        outReady   = 1'b0;
        startS     = 1'b0;
        spikeInS   = 4'b0000;
        outReadyS  = 1'b0;

        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_valid", 32'(outValid), 32'd0);
        checkOutput("rst_class", 32'(outClass), 32'd0);
        checkOutput("rst_count", 32'(outCount), 32'd0);
        checkOutput("rst_tie", 32'(outTie), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single neuron active for the whole window; start-cycle spike ignored.
        for (int i = 0; i < 10; i++) stimVec[i] = 4'b0100;
        applyStimulus(4'b0100);
        checkOutput("single_latency", 32'(lastLatency), 32'd15);
        checkOutput("single_class", 32'(outClass), 32'd2);
        checkOutput("single_count", 32'(outCount), 32'd10);
        checkOutput("single_tie", 32'(outTie), 32'd0);
        finishHold("single");
        checkOutput("single_retainClass", 32'(outClass), 32'd2);

        // out_ready while idle has no effect.
        outReady = 1'b1;
        repeat (3) @(negedge clk);
        outReady = 1'b0;
        checkOutput("idleReady_busy", 32'(busy), 32'd0);
        checkOutput("idleReady_valid", 32'(outValid), 32'd0);
        checkOutput("idleReady_count", 32'(outCount), 32'd10);

        // Tie between neurons 1 and 3 at five spikes; neuron 0 has four.
        for (int i = 0; i < 4; i++) stimVec[i] = 4'b1011;
        stimVec[4] = 4'b1010;
        for (int i = 5; i < 10; i++) stimVec[i] = 4'b0000;
        applyStimulus(4'b0000);
        checkOutput("tie_class", 32'(outClass), 32'd1);
        checkOutput("tie_count", 32'(outCount), 32'd5);
        checkOutput("tie_tie", 32'(outTie), 32'd1);

        // Hold for 20 cycles with start pulses and spikes: nothing may move.
        holdErr = 0;
        for (int i = 0; i < 20; i++) begin
            start   = (i % 3 == 0);
            spikeIn = 4'b1111;
            @(negedge clk);
            if (outClass !== 2'd1 || outCount !== 16'd5 || outTie !== 1'b1 ||
                outValid !== 1'b1 || busy !== 1'b1) holdErr++;
        end
        start   = 1'b0;
        spikeIn = 4'b0000;
        checkOutput("hold_stableErrors", 32'(holdErr), 32'd0);
        finishHold("hold");
        checkOutput("hold_retainTie", 32'(outTie), 32'd1);

        // Silent window: all counts zero -> class 0, tie set.
        for (int i = 0; i < 10; i++) stimVec[i] = 4'b0000;
        applyStimulus(4'b0000);
        checkOutput("zero_class", 32'(outClass), 32'd0);
        checkOutput("zero_count", 32'(outCount), 32'd0);
        checkOutput("zero_tie", 32'(outTie), 32'd1);

        // Asynchronous reset while holding a result clears it immediately.
        #2 rst = 1'b0;
        #1;
        checkOutput("rstHold_valid", 32'(outValid), 32'd0);
        checkOutput("rstHold_tie", 32'(outTie), 32'd0);
        checkOutput("rstHold_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Reset mid-COUNT discards the window.
        @(negedge clk);
        start   = 1'b1;
        spikeIn = 4'b0010;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("midCount_busyBefore", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("midCount_busy", 32'(busy), 32'd0);
        checkOutput("midCount_valid", 32'(outValid), 32'd0);
        @(negedge clk);
        rst     = 1'b1;
        spikeIn = 4'b0000;
        repeat (3) @(negedge clk);
        checkOutput("midCount_noResult", 32'(outValid), 32'd0);
        for (int i = 0; i < 10; i++) stimVec[i] = 4'b0001;
        applyStimulus(4'b0000);
        checkOutput("afterRst_latency", 32'(lastLatency), 32'd15);
        checkOutput("afterRst_class", 32'(outClass), 32'd0);
        checkOutput("afterRst_count", 32'(outCount), 32'd10);
        checkOutput("afterRst_tie", 32'(outTie), 32'd0);
        finishHold("afterRst");

        // Saturating 3-bit counters: ten spikes on neuron 0 stop at 7.
        begin
            int cyc;
            @(negedge clk);
            startS = 1'b1;
            @(negedge clk);
            startS   = 1'b0;
            spikeInS = 4'b0001;
            repeat (10) @(negedge clk);
            spikeInS = 4'b0000;
            cyc = 11;
            while (!outValidS && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            checkOutput("sat_valid", 32'(outValidS), 32'd1);
            checkOutput("sat_count", 32'(outCountS), 32'd7);
            checkOutput("sat_class", 32'(outClassS), 32'd0);
            checkOutput("sat_tie", 32'(outTieS), 32'd0);
            outReadyS = 1'b1;
            @(negedge clk);
            outReadyS = 1'b0;
            checkOutput("sat_busyLow", 32'(busyS), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
